run_sequencer: RTL

Run controller that sits between the host/testbench and the processor core. It parks the core in reset and owns the single data memory port while idle, so the host can load operands and read results. On a go pulse it hands the memory port to the core, holds core reset for a fixed number of cycles, then runs the core. It counts executed cycles until the core halts or a timeout expires. It replaces direct driving of the core's `start` input and the free-running instruction counter.

---
 rtl/run_sequencer_pkg.sv | 6 +
 rtl/run_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/run_sequencer_pkg.sv
// RunSeq_def: shared state encoding and default timing for run_sequencer.
package RunSeq_def;
    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} RUN_STATE;
    localparam int          RST_CYCLES_DEF = 2;
    localparam logic [15:0] TIMEOUT_DEF    = 16'hFFFF;
endpackage

// File: rtl/run_sequencer.sv
// run_sequencer: parks the core in reset, arbitrates the data memory port
// between host and core, and counts run cycles until halt or timeout.
module run_sequencer
    import RunSeq_def::*;
#(
    parameter int               ADDR_W     = 8,
    parameter int               DATA_W     = 8,
    parameter int               CNT_W      = 16,
    parameter int               RST_CYCLES = RST_CYCLES_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT    = CNT_W'(TIMEOUT_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_go,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              core_start,
    input  logic              core_halt,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic              core_mem_read,
    input  logic              core_mem_write,
    input  logic [DATA_W-1:0] core_mem_wdata,
    output logic [DATA_W-1:0] core_mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    RUN_STATE          state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              timeout_q, timeout_d;
    logic              host_ack_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              core_start_q, busy_q, done_q;
    logic              host_own, host_exec, go;

    assign host_own  = (state_q == IDLE) || (state_q == DONE);
    assign go        = host_own && host_go;
    // a pending go takes the port, so the request waits for the next DONE
    assign host_exec = host_req && !host_ack_q && host_own && !host_go;

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        if (go) begin
            state_d       = RESET;
            rst_cnt_d     = '0;
            cycle_count_d = '0;
            timeout_d     = 1'b0;
        end else if (state_q == RESET) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == RC_LAST) state_d = RUN;
        end else if (state_q == RUN) begin
            if (core_halt) begin
                state_d = DONE;
            end else if (cycle_count_q == TIMEOUT) begin
                state_d   = DONE;
                timeout_d = 1'b1;
            end else begin
                cycle_count_d = cycle_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            host_ack_q    <= 1'b0;
            host_rdata_q  <= '0;
            core_start_q  <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
            host_ack_q    <= host_exec;
            host_rdata_q  <= (host_exec && !host_we) ? mem_rdata : host_rdata_q;
            core_start_q  <= state_d != RUN;
            busy_q        <= (state_d == RESET) || (state_d == RUN);
            done_q        <= state_d == DONE;
        end
    end

    assign mem_addr       = host_own ? host_addr : core_mem_addr;
    assign mem_read       = host_own ? host_exec && !host_we : core_mem_read;
    assign mem_write      = host_own ? host_exec && host_we : core_mem_write;
    assign mem_wdata      = host_own ? host_wdata : core_mem_wdata;
    assign core_mem_rdata = host_own ? '0 : mem_rdata;

    assign host_ack    = host_ack_q;
    assign host_rdata  = host_rdata_q;
    assign core_start  = core_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
endmodule
